// File: rtl/booth_mult_seq_if.sv
// Bus between the multdiv controller and booth_mult_seq.
// Carries the start/operand/result handshake and the operand/sum link to the
// shared WIDTH-bit carry-lookahead adder that sits outside the multiplier.
// The master side issues operations and owns the adder.
// The slave side is the multiplier itself.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  // Operation request
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;

  // Shared adder link: operands out of the multiplier, sum back in the same cycle
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;

  // Completion
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB, add_sum,
    input  add_a, add_b, add_cin, data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB, add_sum,
    output add_a, add_b, add_cin, data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: multi-cycle signed WIDTH x WIDTH radix-2 Booth multiplier.
// Each BUSY cycle it drives one add/subtract operand set into an external
// WIDTH-bit carry-lookahead adder and folds the same-cycle sum back into the
// {AC, Q, q_1} shift register. It returns the low WIDTH product bits and a
// flag that is set when the full product does not fit in WIDTH signed bits.
//
// Timing: the start edge loads the operands. Edges 1..WIDTH after it each
// perform one Booth iteration. Edge WIDTH+1 latches the result and raises
// data_resultRDY, which stays high for exactly that one cycle (the DONE state).
//
// Optional feature, macro MULTDIV_ZERO_BYPASS_EN:
//   defined   - a zero operand on the start edge skips every iteration. The
//               result (0, no exception) is ready one edge after the start.
//   undefined - zero operands run the full WIDTH-iteration path.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  booth_mult_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of a + b (+cin) as seen by a WIDTH-bit adder.
  function automatic logic add_overflow(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // The product fits in WIDTH signed bits iff the upper half is a pure
  // sign extension of the low half's MSB.
  function automatic logic product_fits(input logic [WIDTH-1:0] hi,
                                        input logic             lo_msb);
    return hi == {WIDTH{lo_msb}};
  endfunction

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  ac_q, ac_d;
  logic signed [WIDTH-1:0]  q_q, q_d;
  logic                     q1_q, q1_d;
  logic signed [WIDTH-1:0]  m_q, m_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [WIDTH-1:0]         result_q, result_d;
  logic                     exc_q, exc_d;
  logic                     rdy_q, rdy_d;

  logic                     iterating;
  logic [WIDTH-1:0]         add_a_c;
  logic [WIDTH-1:0]         add_b_c;
  logic                     add_cin_c;
  logic                     ov;
  logic                     sign_fix;

  // Adder operand selection from the Booth pair {Q[0], q_1}; zero outside iterations.
  always_comb begin
    add_a_c   = '0;
    add_b_c   = '0;
    add_cin_c = 1'b0;
    iterating = (state_q == BUSY) && (count_q < LAST_ITER);
    if (iterating) begin
      add_a_c = ac_q;
      case ({q_q[0], q1_q})
        2'b01: begin
          add_b_c = m_q;
        end
        2'b10: begin
          add_b_c   = ~m_q;
          add_cin_c = 1'b1;
        end
        default: begin
          add_b_c   = '0;
          add_cin_c = 1'b0;
        end
      endcase
    end
    // A wrapped sum has the wrong MSB; the true sign is the flipped MSB.
    ov       = add_overflow(add_a_c, add_b_c, bus.add_sum);
    sign_fix = bus.add_sum[WIDTH-1] ^ ov;
  end

  // Next-state logic for the controller and the {AC, Q, q_1} shift register.
  always_comb begin
    state_d  = state_q;
    ac_d     = ac_q;
    q_d      = q_q;
    q1_d     = q1_q;
    m_d      = m_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (bus.ctrl_MULT) begin
      // A start in any state (including mid-op) reloads and restarts.
      state_d = BUSY;
      m_d     = bus.data_operandA;
      q_d     = bus.data_operandB;
      ac_d    = '0;
      q1_d    = 1'b0;
      count_d = '0;
`ifdef MULTDIV_ZERO_BYPASS_EN
      // Skip straight to the finishing cycle with an all-zero product.
      if ((bus.data_operandA == '0) || (bus.data_operandB == '0)) begin
        q_d     = '0;
        count_d = LAST_ITER;
      end
`endif
    end else begin
      case (state_q)
        BUSY: begin
          if (iterating) begin
            {ac_d, q_d, q1_d} = {sign_fix, bus.add_sum, q_q};
            count_d           = count_q + CNT_W'(1);
          end else begin
            result_d = q_q;
            exc_d    = ~product_fits(ac_q, q_q[WIDTH-1]);
            rdy_d    = 1'b1;
            state_d  = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // All state, including the registered outputs, updates here with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ac_q     <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ac_q     <= ac_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.add_a          = add_a_c;
  assign bus.add_b          = add_b_c;
  assign bus.add_cin        = add_cin_c;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq (WIDTH=32) with the shared adder modelled in place.
// Table vectors plus hand-written abort/reset/back-to-back sequences, then
// random signed pairs; expectations travel through a scoreboard queue.
module tb_booth_mult_seq;

  localparam int W = 32;
`ifdef MULTDIV_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  localparam int FULL_LAT = 33;

  logic clock = 1'b0;
  logic reset;

  booth_mult_seq_if #(.WIDTH(W)) bus ();

  assign bus.add_sum = bus.add_a + bus.add_b + {{(W-1){1'b0}}, bus.add_cin};

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] r;
    logic         e;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    logic signed [63:0] p;
    p     = $signed(a) * $signed(b);
    x.r   = p[W-1:0];
    x.e   = (p != {{32{p[31]}}, p[31:0]});
    x.lat = ((a == '0) || (b == '0)) ? ZLAT : FULL_LAT;
    return x;
  endfunction

  // Drive a one-cycle start; returns 1 ns after the sampling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Count edges until RDY, then pop the scoreboard and compare.
  task automatic wait_done(input string name);
    int   n;
    exp_t x;
    n = 0;
    while (!bus.data_resultRDY && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!bus.data_resultRDY) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: no RDY within %0d edges", name, n);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: RDY with empty scoreboard", name);
      return;
    end
    x = sb.pop_front();
    check({name, " latency"}, n, x.lat);
    check({name, " result"}, bus.data_result, x.r);
    check({name, " exception"}, {31'b0, bus.data_exception}, {31'b0, x.e});
  endtask

  // Advance some edges and require that RDY never rises.
  task automatic expect_quiet(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) seen++;
    end
    check({name, " spurious RDY count"}, seen, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " result"}, bus.data_result, '0);
    check({name, " exception"}, {31'b0, bus.data_exception}, '0);
    check({name, " rdy"}, {31'b0, bus.data_resultRDY}, '0);
    check({name, " add_a"}, bus.add_a, '0);
    check({name, " add_b"}, bus.add_b, '0);
    check({name, " add_cin"}, {31'b0, bus.add_cin}, '0);
  endtask

  initial begin
    vt[0]  = '{32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vt[1]  = '{32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1};
    vt[2]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vt[3]  = '{32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    vt[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vt[5]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1};
    vt[6]  = '{32'h00010000, 32'h00008000, 32'h80000000, 1'b1};
    vt[7]  = '{32'h00010000, 32'hFFFF8000, 32'h80000000, 1'b0};
    vt[8]  = '{32'h00000064, 32'hFFFFFF9C, 32'hFFFFD8F0, 1'b0};
    vt[9]  = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vt[10] = '{32'h00000000, 32'h0000007B, 32'h00000000, 1'b0};
    vt[11] = '{32'h0000007B, 32'h00000000, 32'h00000000, 1'b0};

    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset state");
    @(negedge clock);
    reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      exp_t x;
      x.r   = vt[i].r;
      x.e   = vt[i].e;
      x.lat = ((vt[i].a == '0) || (vt[i].b == '0)) ? ZLAT : FULL_LAT;
      start_op(vt[i].a, vt[i].b);
      sb.push_back(x);
      wait_done($sformatf("vec%0d", i));
    end

    // Results hold after the RDY pulse
    expect_quiet(5, "hold");
    check("hold result", bus.data_result, 32'h00000000);
    start_op(32'd11, 32'd13);
    sb.push_back('{32'd143, 1'b0, FULL_LAT});
    wait_done("hold op");
    expect_quiet(5, "hold2");
    check("hold2 result", bus.data_result, 32'd143);

    // Abort: 5*5 restarted at iteration 10 by 6*(-4); only one RDY
    start_op(32'd5, 32'd5);
    expect_quiet(9, "abort pre");
    start_op(32'd6, 32'hFFFFFFFC);
    sb.push_back('{32'hFFFFFFE8, 1'b0, FULL_LAT});
    wait_done("abort");
    expect_quiet(40, "abort post");

    // Reset at iteration 20 of 9*9: no RDY, outputs cleared, then 3*3
    start_op(32'd9, 32'd9);
    expect_quiet(19, "rst pre");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_all_zero("mid-op reset");
    expect_quiet(40, "rst post");
    start_op(32'd3, 32'd3);
    sb.push_back('{32'd9, 1'b0, FULL_LAT});
    wait_done("after reset");

    // New start in the RDY cycle: RDY already pulsed, new op proceeds
    start_op(32'd7, 32'hFFFFFFFD);
    sb.push_back('{32'hFFFFFFEB, 1'b0, FULL_LAT});
    wait_done("b2b first");
    start_op(32'hFFFFFFFB, 32'hFFFFFFFA);
    sb.push_back('{32'd30, 1'b0, FULL_LAT});
    wait_done("b2b second");

    // Random signed pairs with extreme values mixed in
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 7))
        0: a = 32'h7FFFFFFF;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h7FFFFFFF;
        1: b = 32'h80000000;
        2: b = $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      start_op(a, b);
      sb.push_back(model(a, b));
      wait_done($sformatf("rand%0d a=%08h b=%08h", i, a, b));
    end

    check("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
